// File: rtl/pattern_pkg.sv
// Shared types, default sizes and the length-mask helper for the pattern scan controller.
package pattern_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StScan = 2'd2,
        StDone = 2'd3
    } state_t;

    localparam int unsigned DEF_PAT_W = 8;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DEF_WIN_W = 16;
    localparam int unsigned MAX_PAT_W = 64;

    // Low `len` bits set; callers truncate to their own pattern width.
    function automatic logic [MAX_PAT_W-1:0] len_mask(input int unsigned len);
        logic [MAX_PAT_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_PAT_W; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Shift register, fill counter and masked compare for serial pattern matching.
// PATTERN_OVERLAP_EN keeps fill on a match so overlapping occurrences are counted.
module pattern_match_core
    import pattern_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             match_now
);

    logic [PAT_W-1:0] sr_q, sr_next, mask;
    logic [LEN_W-1:0] fill_q, fill_next;

    assign sr_next   = {sr_q[PAT_W-2:0], bit_in};
    assign fill_next = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    assign mask      = PAT_W'(len_mask(32'(len)));
    assign match_now = shift_en && (fill_next >= len) && (((sr_next ^ pattern) & mask) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            fill_q <= '0;
        end else if (clear) begin
            sr_q   <= '0;
            fill_q <= '0;
        end else if (shift_en) begin
            sr_q <= sr_next;
`ifdef PATTERN_OVERLAP_EN
            fill_q <= fill_next;
`else
            fill_q <= match_now ? '0 : fill_next;
`endif
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Run controller: latches config, sequences a scan, counts matches, reports hit/done.
// Overlapping-match counting is selected by PATTERN_OVERLAP_EN in pattern_match_core.
module pattern_scan_ctrl
    import pattern_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1),
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned WIN_W = DEF_WIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             in_valid,
    input  logic             in,
    output logic             in_ready,
    output logic             match,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [CNT_W-1:0] match_count
);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] target_q, count_q;
    logic [WIN_W-1:0] win_cfg_q, win_q, win_next;
    logic             match_q, hit_q;
    logic             accept, match_now, target_now, window_now, cfg_bad;

    assign accept     = in_valid && in_ready;
    assign cfg_bad    = (cfg_len == '0) || (32'(cfg_len) > PAT_W);
    assign win_next   = (win_q == '1) ? win_q : win_q + 1'b1;
    assign target_now = accept && match_now && (count_q + 1'b1 == target_q);
    assign window_now = accept && (win_cfg_q != '0) && (win_next == win_cfg_q);

    pattern_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_q == StArm),
        .shift_en  (accept),
        .bit_in    (in),
        .pattern   (pat_q),
        .len       (len_q),
        .match_now (match_now)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = (cfg_bad || cfg_target == '0) ? StDone : StArm;
            StArm:  state_d = abort ? StDone : StScan;
            StScan: if (abort || target_now || window_now) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q == StArm) || (state_q == StScan);
        in_ready = (state_q == StScan);
        done     = (state_q == StDone);
    end

    assign match       = match_q;
    assign hit         = hit_q;
    assign match_count = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q     <= '0;
            len_q     <= '0;
            target_q  <= '0;
            win_cfg_q <= '0;
            win_q     <= '0;
            count_q   <= '0;
            match_q   <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            match_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        pat_q     <= cfg_pattern;
                        len_q     <= cfg_len;
                        target_q  <= cfg_target;
                        win_cfg_q <= cfg_window;
                        if (cfg_bad || cfg_target == '0) begin
                            hit_q   <= !cfg_bad;
                            count_q <= '0;
                        end
                    end
                end
                StArm: begin
                    win_q   <= '0;
                    count_q <= '0;
                    hit_q   <= 1'b0;
                end
                StScan: begin
                    if (accept) begin
                        win_q <= win_next;
                        if (match_now && count_q != target_q) begin
                            count_q <= count_q + 1'b1;
                            match_q <= 1'b1;
                        end
                        // A bit accepted alongside abort still counts but never succeeds.
                        if (target_now && !abort) hit_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: directed scenarios plus randomized runs vs a model.
module tb_pattern_scan_ctrl;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned WIN_W = 16;
`ifdef PATTERN_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, start, abort, in_valid, in_bit;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_target;
    logic [WIN_W-1:0] cfg_window;
    logic             in_ready, match, busy, done, hit;
    logic [CNT_W-1:0] match_count;

    int tests_run = 0;
    int fails = 0;

    pattern_scan_ctrl #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W),
        .WIN_W (WIN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .cfg_window  (cfg_window),
        .in_valid    (in_valid),
        .in          (in_bit),
        .in_ready    (in_ready),
        .match       (match),
        .busy        (busy),
        .done        (done),
        .hit         (hit),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input int p, input int l, input int t, input int w);
        cfg_pattern = PAT_W'(p);
        cfg_len     = LEN_W'(l);
        cfg_target  = CNT_W'(t);
        cfg_window  = WIN_W'(w);
    endtask

    // IDLE -> ARM -> SCAN
    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic feed(input bit b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; abort = 0; in_valid = 0; in_bit = 0;
        configure(0, 0, 0, 0);
        tick(); tick();
        tests_run++;
        if ({busy, done, hit, in_ready, match, match_count} !== '0) begin
            fails++;
            $display("FAIL reset outputs: got %b want 0",
                     {busy, done, hit, in_ready, match, match_count});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_overlap();
        int nb;
        bit exp_m;
        nb = OVERLAP ? 4 : 6;
        configure(8'b111, 3, 2, 0);
        launch();
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL overlap in_ready: got %b want 1", in_ready);
        end
        for (int i = 1; i <= nb; i++) begin
            feed(1'b1);
            exp_m = OVERLAP ? (i >= 3) : (i == 3 || i == 6);
            tests_run++;
            if (match !== exp_m) begin
                fails++; $display("FAIL overlap match bit %0d: got %b want %b", i, match, exp_m);
            end
        end
        tests_run++;
        if ({done, hit, match_count} !== {1'b1, 1'b1, 8'd2}) begin
            fails++;
            $display("FAIL overlap end: got done=%b hit=%b count=%0d want 1 1 2",
                     done, hit, match_count);
        end
        tick();
        tests_run++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL overlap done pulse width: got %b want 0", done);
        end
    endtask

    task automatic test_window_exhaust();
        configure(8'b101, 3, 1, 5);
        launch();
        for (int i = 1; i <= 5; i++) begin
            feed(1'b0);
            tests_run++;
            if (match !== 1'b0) begin
                fails++; $display("FAIL window match bit %0d: got %b want 0", i, match);
            end
        end
        tests_run++;
        if ({done, hit, in_ready, match_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL window end: got done=%b hit=%b rdy=%b count=%0d want 1 0 0 0",
                     done, hit, in_ready, match_count);
        end
        tick();
    endtask

    task automatic test_window_tie();
        configure(8'b101, 3, 1, 3);
        launch();
        feed(1'b1); feed(1'b0); feed(1'b1);
        tests_run++;
        if ({match, done, hit, match_count} !== {1'b1, 1'b1, 1'b1, 8'd1}) begin
            fails++;
            $display("FAIL tie end: got match=%b done=%b hit=%b count=%0d want 1 1 1 1",
                     match, done, hit, match_count);
        end
        tick();
    endtask

    task automatic test_bad_cfg();
        int lens[3] = '{0, 1, 9};
        int tgts[3] = '{1, 0, 1};
        bit hits[3] = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            configure(1, lens[k], tgts[k], 0);
            start = 1'b1;
            tick();
            start = 1'b0;
            tests_run++;
            if ({done, hit, busy, in_ready, match_count} !== {1'b1, hits[k], 1'b0, 1'b0, 8'd0})
            begin
                fails++;
                $display("FAIL badcfg %0d: got done=%b hit=%b busy=%b rdy=%b count=%0d want 1 %b 0 0 0",
                         k, done, hit, busy, in_ready, match_count, hits[k]);
            end
            tick();
            tests_run++;
            if ({done, in_ready} !== 2'b00) begin
                fails++; $display("FAIL badcfg %0d after: got done/rdy=%b want 00", k, {done, in_ready});
            end
        end
    endtask

    task automatic test_abort();
        configure(8'b10, 2, 4, 0);
        launch();
        start = 1'b1;  // ignored while scanning
        feed(1'b1); feed(1'b0); feed(1'b1); feed(1'b0);
        start = 1'b0;
        tests_run++;
        if ({busy, match_count} !== {1'b1, 8'd2}) begin
            fails++; $display("FAIL abort pre: got busy=%b count=%0d want 1 2", busy, match_count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests_run++;
        if ({done, hit, match_count} !== {1'b1, 1'b0, 8'd2}) begin
            fails++;
            $display("FAIL abort end: got done=%b hit=%b count=%0d want 1 0 2", done, hit, match_count);
        end
        tick();
        launch();
        tests_run++;
        if ({busy, in_ready, match_count} !== {1'b1, 1'b1, 8'd0}) begin
            fails++;
            $display("FAIL abort rearm: got busy=%b rdy=%b count=%0d want 1 1 0",
                     busy, in_ready, match_count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        configure(8'b1, 1, 10, 0);
        launch();
        feed(1'b1); feed(1'b1); feed(1'b1);
        tests_run++;
        if (match_count !== 8'd3) begin
            fails++; $display("FAIL arst pre count: got %0d want 3", match_count);
        end
        in_valid = 1'b1;
        in_bit   = 1'b1;
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, hit, in_ready, match, match_count} !== '0) begin
            fails++;
            $display("FAIL arst outputs: got %b want 0", {busy, done, hit, in_ready, match, match_count});
        end
        #2 rst = 1'b0;
        tick();
        configure(8'b101, 3, 1, 3);
        launch();
        feed(1'b1); feed(1'b0); feed(1'b1);
        tests_run++;
        if ({done, hit, match_count} !== {1'b1, 1'b1, 8'd1}) begin
            fails++;
            $display("FAIL arst rerun: got done=%b hit=%b count=%0d want 1 1 1", done, hit, match_count);
        end
        tick();
    endtask

    task automatic test_random();
        bit   hist[$];
        int   len, target, window, acc, cnt;
        bit   v, b, ab, m, fin, exp_hit;
        logic [PAT_W-1:0] pat;
        for (int r = 0; r < 30; r++) begin
            len    = $urandom_range(1, 4);
            pat    = PAT_W'($urandom);
            target = $urandom_range(1, 4);
            window = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(len, 30);
            configure(int'(pat), len, target, window);
            launch();
            hist.delete();
            acc = 0;
            cnt = 0;
            for (int cyc = 0; cyc < 200; cyc++) begin
                tests_run++;
                if (in_ready !== 1'b1) begin
                    fails++; $display("FAIL rand run %0d cyc %0d in_ready: got %b want 1", r, cyc, in_ready);
                end
                v  = ($urandom_range(0, 3) != 0);
                b  = 1'($urandom);
                ab = (cyc == 199) || ($urandom_range(0, 59) == 0);
                m  = 1'b0;
                if (v) begin
                    hist.push_back(b);
                    acc++;
                    if (hist.size() >= len) begin
                        m = 1'b1;
                        for (int k = 0; k < len; k++)
                            if (hist[hist.size() - 1 - k] != pat[k]) m = 1'b0;
                    end
                    if (m) begin
                        cnt++;
                        if (!OVERLAP) hist.delete();
                    end
                end
                exp_hit = !ab && m && (cnt == target);
                fin     = ab || (m && cnt == target) || (v && window != 0 && acc == window);
                in_valid = v;
                in_bit   = b;
                abort    = ab;
                tick();
                in_valid = 1'b0;
                abort    = 1'b0;
                tests_run++;
                if ({match, done, match_count} !== {m, fin, CNT_W'(cnt)}) begin
                    fails++;
                    $display("FAIL rand run %0d cyc %0d: got match=%b done=%b count=%0d want %b %b %0d",
                             r, cyc, match, done, match_count, m, fin, cnt);
                end
                if (fin) begin
                    tests_run++;
                    if (hit !== exp_hit) begin
                        fails++; $display("FAIL rand run %0d hit: got %b want %b", r, hit, exp_hit);
                    end
                    break;
                end
            end
            // Drains DONE; if a failure left the DUT scanning, abort it back to idle.
            abort = 1'b1;
            tick();
            abort = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_window_exhaust();
        test_window_tie();
        test_bad_cfg();
        test_abort();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
